// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit.
package shift_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x,
                                                     input int unsigned      w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[6'(i)] = x[6'(w - 1 - i)];
            end
        end
        return r;
    endfunction

    // Right-type ops run through the left-shift datapath on a reversed operand.
    function automatic logic is_right(input shift_op_e op);
        return (op == SRL) || (op == SRA) || (op == ROR);
    endfunction

    // Rotates feed the shifted-out bits back in as fill.
    function automatic logic is_rotate(input shift_op_e op);
        return (op == ROL) || (op == ROR);
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational layer of the log shifter: left shift by SHIFT when enabled.
module shift_layer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHIFT  = 1
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  logic              i_fill,
    input  logic              i_rotate,
    output logic [DATA_W-1:0] o_data_c
);

    logic [SHIFT-1:0] w_low;

    // Low bits entering from the right: wrapped MSBs for rotates, fill bit otherwise.
    always_comb begin
        w_low = {SHIFT{i_fill}};
        if (i_rotate) begin
            w_low = i_data[DATA_W-1 -: SHIFT];
        end
    end

    // Apply the shift only when this layer's shift-amount bit is set.
    always_comb begin
        o_data_c = i_data;
        if (i_en) begin
            o_data_c = {i_data[DATA_W-SHIFT-1:0], w_low};
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined shift unit: SLL/SRL/SRA/ROL/ROR over a log shifter split into
// PIPE_STAGES register stages, with valid/ready handshake, tag and flush.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  shift_op_e         i_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_tag
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam int unsigned LAST    = PIPE_STAGES - 1;

    // Elaboration-time parameter sanity.
    if (DATA_W < 8 || DATA_W > MAX_W || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
        $error("shift_unit_pipe: DATA_W must be a power of two in 8..64");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > SHAMT_W) begin : g_bad_stages
        $error("shift_unit_pipe: PIPE_STAGES must be in 1..log2(DATA_W)");
    end

    // Entry decode.
    shift_op_e          w_op;
    logic [DATA_W-1:0]  w_entry_data;
    logic               w_entry_fill;
    logic               w_adv;
    logic               w_unused_b;

    // Per-stage inputs (stage 0 from the ports, stage s from register s-1).
    logic [DATA_W-1:0]  w_in_data   [PIPE_STAGES];
    logic [SHAMT_W-1:0] w_in_sh     [PIPE_STAGES];
    shift_op_e          w_in_op     [PIPE_STAGES];
    logic               w_in_fill   [PIPE_STAGES];
    logic [TAG_W-1:0]   w_in_tag    [PIPE_STAGES];
    logic               w_in_valid  [PIPE_STAGES];

    // Per-stage datapath results and next register values.
    logic [DATA_W-1:0]  w_stage_out [PIPE_STAGES];
    logic [DATA_W-1:0]  w_nxt_data  [PIPE_STAGES];
    logic [DATA_W-1:0]  w_exit_data;

    // Layer chain.
    logic [DATA_W-1:0]  w_layer_in  [SHAMT_W];
    logic [DATA_W-1:0]  w_layer_out [SHAMT_W];

    // Pipeline registers at the end of each stage.
    logic [DATA_W-1:0]  r_data  [PIPE_STAGES];
    logic [SHAMT_W-1:0] r_sh    [PIPE_STAGES];
    shift_op_e          r_op    [PIPE_STAGES];
    logic               r_fill  [PIPE_STAGES];
    logic [TAG_W-1:0]   r_tag   [PIPE_STAGES];
    logic               r_valid [PIPE_STAGES];

    // Only the low SHAMT_W bits of operand b select the amount.
    assign w_unused_b = ^i_operand_b[DATA_W-1:SHAMT_W];

    // The whole pipe moves together; it holds only when the output is blocked.
    assign w_adv   = !r_valid[LAST] || i_ready;
    assign o_ready = w_adv;

    // Normalise the opcode, reverse right-type operands and pick the fill bit.
    always_comb begin
        w_op = SLL;
        case (i_op)
            SLL, SRL, SRA, ROL, ROR: w_op = i_op;
            default:                 w_op = SLL;
        endcase
        w_entry_data = i_operand_a;
        if (is_right(w_op)) begin
            w_entry_data = DATA_W'(bit_reverse(MAX_W'(i_operand_a), DATA_W));
        end
        w_entry_fill = (w_op == SRA) && i_operand_a[DATA_W-1];
    end

    // Stage input bundles.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage_in
        if (s == 0) begin : g_from_port
            assign w_in_data[s]  = w_entry_data;
            assign w_in_sh[s]    = i_operand_b[SHAMT_W-1:0];
            assign w_in_op[s]    = w_op;
            assign w_in_fill[s]  = w_entry_fill;
            assign w_in_tag[s]   = i_tag;
            assign w_in_valid[s] = i_valid;
        end else begin : g_from_reg
            assign w_in_data[s]  = r_data[s-1];
            assign w_in_sh[s]    = r_sh[s-1];
            assign w_in_op[s]    = r_op[s-1];
            assign w_in_fill[s]  = r_fill[s-1];
            assign w_in_tag[s]   = r_tag[s-1];
            assign w_in_valid[s] = r_valid[s-1];
        end
    end

    // Layer k shifts by 2^k and lives in stage floor(k*PIPE_STAGES/SHAMT_W).
    // A stage boundary falls before k exactly when (k*PIPE_STAGES) mod SHAMT_W < PIPE_STAGES.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
        localparam int unsigned STG     = (32'(k) * PIPE_STAGES) / SHAMT_W;
        localparam bit          FIRST_L = ((32'(k) * PIPE_STAGES) % SHAMT_W) < PIPE_STAGES;
        localparam bit          LAST_L  = (32'(k) == SHAMT_W - 1) ||
                                          (((32'(k) + 1) * PIPE_STAGES) % SHAMT_W) < PIPE_STAGES;

        if (FIRST_L) begin : g_first
            assign w_layer_in[k] = w_in_data[STG];
        end else begin : g_chain
            assign w_layer_in[k] = w_layer_out[k-1];
        end

        shift_layer #(
            .DATA_W (DATA_W),
            .SHIFT  (1 << k)
        ) u_layer (
            .i_data   (w_layer_in[k]),
            .i_en     (w_in_sh[STG][k]),
            .i_fill   (w_in_fill[STG]),
            .i_rotate (is_rotate(w_in_op[STG])),
            .o_data_c (w_layer_out[k])
        );

        if (LAST_L) begin : g_stage_end
            assign w_stage_out[STG] = w_layer_out[k];
        end
    end

    // Undo the entry reversal before the final register so o_data is the result.
    always_comb begin
        w_exit_data = w_stage_out[LAST];
        if (is_right(w_in_op[LAST])) begin
            w_exit_data = DATA_W'(bit_reverse(MAX_W'(w_stage_out[LAST]), DATA_W));
        end
    end

    // Next data value per stage register.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_nxt
        if (s == LAST) begin : g_exit
            assign w_nxt_data[s] = w_exit_data;
        end else begin : g_mid
            assign w_nxt_data[s] = w_stage_out[s];
        end
    end

    // Pipeline registers: advance together, flush clears every valid bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                r_data[s]  <= '0;
                r_sh[s]    <= '0;
                r_op[s]    <= SLL;
                r_fill[s]  <= 1'b0;
                r_tag[s]   <= '0;
                r_valid[s] <= 1'b0;
            end
        end else begin
            if (w_adv) begin
                for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                    r_data[s]  <= w_nxt_data[s];
                    r_sh[s]    <= w_in_sh[s];
                    r_op[s]    <= w_in_op[s];
                    r_fill[s]  <= w_in_fill[s];
                    r_tag[s]   <= w_in_tag[s];
                    r_valid[s] <= w_in_valid[s];
                end
            end
            if (i_flush) begin
                for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                    r_valid[s] <= 1'b0;
                end
            end
        end
    end

    assign o_valid = r_valid[LAST];
    assign o_data  = r_data[LAST];
    assign o_tag   = r_tag[LAST];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed ops, backpressure, flush,
// mid-stream reset, random traffic and two extra width/depth configurations.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned PS = 2;
    localparam int unsigned TW = 5;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            i_valid;
    logic            o_ready;
    shift_op_e       i_op;
    logic [DW-1:0]   i_operand_a;
    logic [DW-1:0]   i_operand_b;
    logic [TW-1:0]   i_tag;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [DW-1:0]   o_data;
    logic [TW-1:0]   o_tag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic sweep_go = 1'b0;
    logic [TW+DW-1:0] q[$];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    shift_unit_pipe #(
        .DATA_W      (DW),
        .PIPE_STAGES (PS),
        .TAG_W       (TW)
    ) u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_tag       (i_tag),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_tag       (o_tag)
    );

    // Reference shifter on the low w bits.
    function automatic logic [63:0] ref_shift(input shift_op_e op, input logic [63:0] a,
                                              input int sh, input int w);
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = a & m;
        case (op)
            SRL: r = x >> sh;
            SRA: begin
                r = x >> sh;
                if (x[6'(w - 1)]) r = r | (m & ~(m >> sh));
            end
            ROL:     r = (x << sh) | (x >> (w - sh));
            ROR:     r = (x >> sh) | (x << (w - sh));
            default: r = x << sh;
        endcase
        return r & m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present one op, wait for acceptance, record its expected result.
    task automatic issue(input shift_op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] tag, input logic [DW-1:0] exp);
        int n;
        i_valid = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b; i_tag = tag;
        for (n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (o_ready) break;
        end
        chk("accept", 64'(o_ready), 64'd1);
        if (o_ready) q.push_back({tag, exp});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 30 && q.size() != 0; n++) begin
            @(posedge i_clk); #1;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Output monitor: pop and compare on every output transfer.
    always @(negedge i_clk) begin
        logic [TW+DW-1:0] e;
        if (i_rst) begin
            q.delete();
        end else begin
            if (o_valid && i_ready) begin
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL out_spurious got=%h exp=none", {o_tag, o_data});
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    total++;
                    assert ({o_tag, o_data} === e) else begin
                        bad++;
                        $error("FAIL out_result got=%h exp=%h", {o_tag, o_data}, e);
                    end
                end
            end
            if (i_flush) q.delete();
        end
    end

    // Extra configurations: random traffic, full-rate output, latency check.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int unsigned SW  = (g == 0) ? 8 : 64;
        localparam int unsigned SP  = (g == 0) ? 3 : 1;
        localparam int unsigned SSH = $clog2(SW);

        logic          s_valid = 1'b0;
        logic          s_ready;
        logic          s_ovalid;
        shift_op_e     s_op = SLL;
        logic [SW-1:0] s_a = '0;
        logic [SW-1:0] s_b = '0;
        logic [SW-1:0] s_data;
        logic [TW-1:0] s_tag = '0;
        logic [TW-1:0] s_otag;
        logic          done = 1'b0;
        logic [TW+SW-1:0] s_q[$];
        int               s_cq[$];

        shift_unit_pipe #(
            .DATA_W      (SW),
            .PIPE_STAGES (SP),
            .TAG_W       (TW)
        ) u_dut (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_valid     (s_valid),
            .o_ready     (s_ready),
            .i_op        (s_op),
            .i_operand_a (s_a),
            .i_operand_b (s_b),
            .i_tag       (s_tag),
            .i_flush     (1'b0),
            .o_valid     (s_ovalid),
            .i_ready     (1'b1),
            .o_data      (s_data),
            .o_tag       (s_otag)
        );

        initial begin
            wait (sweep_go);
            @(posedge i_clk); #1;
            for (int n = 0; n < 80; n++) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_op    = shift_op_e'(3'($urandom_range(0, 7)));
                s_a     = SW'({$urandom(), $urandom()});
                s_b     = SW'($urandom());
                s_tag   = TW'($urandom());
                @(posedge i_clk); #1;
            end
            s_valid = 1'b0;
            repeat (SP + 4) @(posedge i_clk);
            done = 1'b1;
        end

        always @(negedge i_clk) begin
            logic [TW+SW-1:0] e;
            int c;
            if (s_ovalid) begin
                total++;
                assert (s_q.size() != 0) else begin
                    bad++;
                    $error("FAIL sweep%0d_spurious got=%h exp=none", g, {s_otag, s_data});
                end
                if (s_q.size() != 0) begin
                    e = s_q.pop_front();
                    c = s_cq.pop_front();
                    total++;
                    assert ({s_otag, s_data} === e) else begin
                        bad++;
                        $error("FAIL sweep%0d_result got=%h exp=%h", g, {s_otag, s_data}, e);
                    end
                    total++;
                    assert (cyc - c == int'(SP)) else begin
                        bad++;
                        $error("FAIL sweep%0d_latency got=%0d exp=%0d", g, cyc - c, SP);
                    end
                end
            end
            if (s_valid && s_ready) begin
                s_q.push_back({s_tag, SW'(ref_shift(s_op, 64'(s_a), int'(s_b[SSH-1:0]), int'(SW)))});
                s_cq.push_back(cyc);
            end
        end
    end

    initial begin
        i_valid = 1'b0; i_op = SLL; i_operand_a = '0; i_operand_b = '0;
        i_tag = '0; i_flush = 1'b0; i_ready = 1'b1;

        // Reset values.
        #1 i_rst = 1'b1;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_data",  64'(o_data),  64'd0);
        chk("rst_tag",   64'(o_tag),   64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Latency of exactly two cycles, tag preserved.
        issue(SLL, 32'h0000_0001, 32'd31, 5'h1F, 32'h8000_0000);
        chk("lat1_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk); #1;
        chk("lat2_valid", 64'(o_valid), 64'd1);
        chk("lat2_data",  64'(o_data),  64'h8000_0000);
        chk("lat2_tag",   64'(o_tag),   64'h1F);
        @(posedge i_clk); #1;

        // Directed op table, back to back.
        issue(SRA, 32'h8000_0000, 32'd4,          5'h01, 32'hF800_0000);
        issue(SRL, 32'h8000_0000, 32'd4,          5'h02, 32'h0800_0000);
        issue(SLL, 32'h0000_0001, 32'h25,         5'h03, 32'h0000_0020);
        issue(ROL, 32'h8000_0001, 32'd1,          5'h04, 32'h0000_0003);
        issue(ROR, 32'h0000_0003, 32'd1,          5'h05, 32'h8000_0001);
        issue(ROR, 32'h1234_5678, 32'h24,         5'h06, 32'h8123_4567);
        issue(SRA, 32'h7000_0000, 32'd31,         5'h07, 32'h0000_0000);
        issue(SLL, 32'hA5C3_0F96, 32'd0,          5'h08, 32'hA5C3_0F96);
        issue(SRL, 32'hA5C3_0F96, 32'h0000_0020,  5'h09, 32'hA5C3_0F96);
        issue(SRA, 32'hA5C3_0F96, 32'd0,          5'h0A, 32'hA5C3_0F96);
        issue(ROL, 32'hA5C3_0F96, 32'd0,          5'h0B, 32'hA5C3_0F96);
        issue(ROR, 32'hA5C3_0F96, 32'd0,          5'h0C, 32'hA5C3_0F96);
        issue(shift_op_e'(3'd7), 32'h0000_00F0, 32'd4, 5'h0D, 32'h0000_0F00);
        drain();

        // Backpressure: two ops fill the pipe, the third waits.
        i_ready = 1'b0;
        issue(SLL, 32'h0000_00FF, 32'd8, 5'h13, 32'h0000_FF00);
        issue(SRL, 32'hFF00_0000, 32'd8, 5'h14, 32'h00FF_0000);
        i_valid = 1'b1; i_op = ROL; i_operand_a = 32'hF000_000F; i_operand_b = 32'd4; i_tag = 5'h15;
        for (int n = 0; n < 4; n++) begin
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_valid", 64'(o_valid), 64'd1);
            chk("bp_data",  64'(o_data),  64'h0000_FF00);
            chk("bp_tag",   64'(o_tag),   64'h13);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        #1;
        chk("bp_release", 64'(o_ready), 64'd1);
        q.push_back({5'h15, 32'h0000_00FF});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        drain();

        // Flush with two ops in flight and a concurrent input.
        i_ready = 1'b0;
        issue(SLL, 32'h1, 32'd1, 5'h16, 32'h2);
        issue(SLL, 32'h1, 32'd2, 5'h17, 32'h4);
        i_valid = 1'b1; i_op = SLL; i_operand_a = 32'h1; i_operand_b = 32'd3; i_tag = 5'h18;
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("flush_valid", 64'(o_valid), 64'd0);
            @(posedge i_clk); #1;
        end

        // Asynchronous reset mid-stream, then a clean op.
        i_ready = 1'b0;
        issue(ROR, 32'h0000_00F0, 32'd4, 5'h19, 32'h0000_000F);
        issue(SRA, 32'hF000_0000, 32'd4, 5'h1A, 32'hFF00_0000);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_data",  64'(o_data),  64'd0);
        chk("mid_rst_tag",   64'(o_tag),   64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_ready = 1'b1;
        issue(SRA, 32'h8765_4321, 32'hFFFF_FFE8, 5'h0B, 32'hFF87_6543);
        chk("post_rst_lat1", 64'(o_valid), 64'd0);
        @(posedge i_clk); #1;
        chk("post_rst_lat2", 64'(o_valid), 64'd1);
        drain();

        // Random traffic with random output stalls.
        for (int n = 0; n < 60; n++) begin
            i_valid     = ($urandom_range(0, 3) != 0);
            i_ready     = ($urandom_range(0, 3) != 0);
            i_op        = shift_op_e'(3'($urandom_range(0, 7)));
            i_operand_a = $urandom();
            i_operand_b = $urandom();
            i_tag       = TW'($urandom());
            @(negedge i_clk);
            if (i_valid && o_ready) begin
                q.push_back({i_tag, DW'(ref_shift(i_op, 64'(i_operand_a), int'(i_operand_b[4:0]), 32))});
            end
            @(posedge i_clk); #1;
        end
        drain();

        // Other widths and depths.
        sweep_go = 1'b1;
        for (int n = 0; n < 400 && !(g_sweep[0].done && g_sweep[1].done); n++) begin
            @(posedge i_clk);
        end
        chk("sweep_done", 64'({g_sweep[0].done, g_sweep[1].done}), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined shift unit that succeeds the fixed 32-bit combinational left shifter.
- Supports logical left, logical right, arithmetic right and rotate left/right at configurable data width and pipeline depth.
- Sits in the EX stage next to the ALU; carries a tag (destination register index) through the pipe.
- Uses a valid/ready handshake so hazard logic can stall or flush it.

Parameters:
- DATA_W, 32, operand/result width; power of two, 8..64.
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from i_operand_b; derived, not overridden.
- PIPE_STAGES, 2, register stages between input and output, 1..SHAMT_W.
- TAG_W, 5, width of the sideband tag passed through unchanged.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit accepts an input this cycle.
- i_op  in  3  shift_pkg::shift_op_e (SLL, SRL, SRA, ROL, ROR).
- i_operand_a  in  DATA_W  value to shift.
- i_operand_b  in  DATA_W  shift source; only [SHAMT_W-1:0] is used.
- i_tag  in  TAG_W  sideband tag.
- i_flush  in  1  kill all in-flight operations.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  DATA_W  shifted result.
- o_tag  out  TAG_W  tag of o_data.

Behaviour:
- Reset: every stage valid bit is 0, so o_valid=0 and o_ready=1. Data and tag registers are cleared to 0, so o_data=0 and o_tag=0.
- Global advance: adv = !o_valid || i_ready. When adv=1, all stages shift forward by one. When adv=0, all registers hold (no bubble collapse).
- o_ready = adv.
- Input transfer occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready.
- Latency: exactly PIPE_STAGES cycles from the input transfer to o_valid, with no backpressure. Throughput is 1 op/cycle.
- Order is preserved; the pipe never drops or duplicates an op.
- Shift amount sh = i_operand_b[SHAMT_W-1:0]. Upper bits are ignored, so amounts at or above DATA_W wrap modulo DATA_W.
- Right-type ops (SRL, SRA, ROR) bit-reverse the operand on entry and the result on exit, sharing the left-shift datapath.
- Fill bit per layer:
  - SLL/SRL: 0.
  - SRA: original operand MSB.
  - ROL/ROR: the bits shifted out (rotate).
- Datapath is SHAMT_W layers; layer k shifts by 2^k when sh[k]=1.
- Layer k sits in stage floor(k*PIPE_STAGES/SHAMT_W). The pipeline register sits at the end of each stage.
- Each stage register carries: partial data, remaining sh bits, op, fill bit, tag, valid.
- sh=0: o_data equals i_operand_a for every op.
- Flush: i_flush=1 clears all valid bits on the next edge, regardless of adv.
  - An input presented in the same cycle as i_flush is discarded.
  - Data registers need not clear.
- Simultaneous input and output transfer with a full pipe is legal; steady state holds throughput.
- Asynchronous reset asserted mid-operation: all valid bits drop immediately, outputs reach reset values, and in-flight ops are lost.
- Illegal i_op encodings behave as SLL.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [2:0] shift_op_e: SLL=0, SRL=1, SRA=2, ROL=3, ROR=4.
  - function bit_reverse.
  - function is_right(op).
- Sub-module shift_layer (parameters DATA_W, SHIFT): one combinational 2^k layer.
  - Inputs: data, enable, fill bit, rotate flag.
  - The top instantiates SHAMT_W layers via generate.
- Top owns: stage assignment, pipeline registers, handshake, flush.

Test Plan:
- DATA_W=32, PIPE_STAGES=2: SLL a=0x0000_0001 b=31 -> o_data=0x8000_0000 with o_valid two cycles after acceptance; tag 0x1F preserved.
- SRA a=0x8000_0000 b=4 -> 0xF800_0000. SRL same operands -> 0x0800_0000. b=0x25 (sh=5) SLL a=0x1 -> 0x0000_0020.
- ROL a=0x8000_0001 b=1 -> 0x0000_0003. ROR a=0x0000_0003 b=1 -> 0x8000_0001. Any op with b=0 -> a unchanged.
- Backpressure:
  - Stimulus: issue 3 back-to-back ops, hold i_ready=0 for 4 cycles, then release.
  - Required: o_ready=0 while the pipe is full, o_data/o_tag stable while stalled, results emerge in order with no loss.
- Flush and reset:
  - i_flush with 2 ops in flight plus a concurrent input -> no o_valid ever appears for those 3.
  - Assert i_rst mid-stream -> o_valid=0 and o_ready=1 in the same cycle.
  - After release, a new op completes normally.
- Parameter sweep: DATA_W=8/16/64 and PIPE_STAGES=1..SHAMT_W, randomised ops checked against a reference model. Latency always equals PIPE_STAGES.
